// File: rtl/scroll_step_gen_if.sv
// scroll_step_gen_if: control/status bundle for the scroll position sequencer.
// The controller side (master) drives enable, mode and restart and observes
// the position, step pulse, direction and done flag produced by the
// sequencer (slave).
// Optional macro RATE_SEL_EN adds the 2-bit rate_sel divider select.
interface scroll_step_gen_if #(
  parameter int POS_W = 3
);
  logic             en;
  logic [1:0]       mode;
  logic             restart;
`ifdef RATE_SEL_EN
  logic [1:0]       rate_sel;
`endif
  logic [POS_W-1:0] pos;
  logic             step;
  logic             dir;
  logic             done;

`ifdef RATE_SEL_EN
  modport master (output en, mode, restart, rate_sel, input pos, step, dir, done);
  modport slave  (input en, mode, restart, rate_sel, output pos, step, dir, done);
`else
  modport master (output en, mode, restart, input pos, step, dir, done);
  modport slave  (input en, mode, restart, output pos, step, dir, done);
`endif
endinterface

// File: rtl/scroll_step_gen.sv
// scroll_step_gen: position sequencer for scrolling / barrel-shift displays.
// A prescaler divides clk by DIV = CLK_HZ/STEP_HZ and every tick advances the
// position index 0..POS_MAX according to the run mode (wrap-up, wrap-down,
// ping-pong, one-shot). All outputs come straight from flops; step and the
// new pos appear together in the cycle after the tick condition.
// Optional macro RATE_SEL_EN: adds rate_sel, a post-divider of 1/2/4/8 ticks.
module scroll_step_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 2,
  parameter int POS_MAX = 7
) (
  input logic              clk,
  input logic              nrst,
  scroll_step_gen_if.slave bus
);
  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int POS_W = (POS_MAX < 1) ? 1 : $clog2(POS_MAX + 1);
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  if (DIV < 2) begin : g_div_chk
    $error("scroll_step_gen: CLK_HZ/STEP_HZ must be at least 2");
  end
  if (POS_MAX < 1) begin : g_pos_chk
    $error("scroll_step_gen: POS_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_ONCE = 2'b11
  } mode_e;

  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [POS_W-1:0] pos_r, pos_n;
  logic             step_r, step_n;
  logic             dir_r, dir_n;
  logic             done_r, done_n;
  logic [1:0]       mode_q_r;

  logic             load_s;
  logic             run_s;
  logic             tick_s;
  logic             adv_s;
  logic [POS_W-1:0] pos_inc_s;
  logic [POS_W-1:0] pos_dec_s;

  // A restart pulse or any change of the mode input reloads the start value.
  assign load_s    = bus.restart | (bus.mode != mode_q_r);
  // The prescaler only runs while enabled and before a one-shot completes.
  assign run_s     = bus.en & ~done_r;
  assign tick_s    = run_s & (cnt_r == CNT_LAST);
  assign pos_inc_s = pos_r + POS_ONE;
  assign pos_dec_s = pos_r - POS_ONE;

`ifdef RATE_SEL_EN
  logic [2:0] post_r, post_n;
  logic [1:0] rate_q_r;

  // Last post-counter value for a given rate select: (1 << rate_sel) - 1.
  function automatic logic [2:0] post_last(input logic [1:0] rs);
    case (rs)
      2'd0:    post_last = 3'd0;
      2'd1:    post_last = 3'd1;
      2'd2:    post_last = 3'd3;
      2'd3:    post_last = 3'd7;
      default: post_last = 3'd0;
    endcase
  endfunction

  // Post-counter: counts ticks; a rate change or reload restarts the count.
  always_comb begin
    post_n = post_r;
    adv_s  = 1'b0;
    if (load_s || (bus.rate_sel != rate_q_r)) begin
      post_n = 3'd0;
    end else if (tick_s) begin
      if (post_r >= post_last(bus.rate_sel)) begin
        post_n = 3'd0;
        adv_s  = 1'b1;
      end else begin
        post_n = post_r + 3'd1;
      end
    end else begin
      post_n = post_r;
    end
  end

  // Post-counter and rate-select history registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      post_r   <= 3'd0;
      rate_q_r <= 2'd0;
    end else begin
      post_r   <= post_n;
      rate_q_r <= bus.rate_sel;
    end
  end
`else
  assign adv_s = tick_s;
`endif

  // Prescaler: exactly DIV enabled clocks per tick, cleared on reload.
  always_comb begin
    cnt_n = cnt_r;
    if (load_s) begin
      cnt_n = '0;
    end else if (tick_s) begin
      cnt_n = '0;
    end else if (run_s) begin
      cnt_n = cnt_r + CNT_ONE;
    end else begin
      cnt_n = cnt_r;
    end
  end

  // Position, direction and done: start value on reload, mode rule on advance.
  always_comb begin
    pos_n  = pos_r;
    dir_n  = dir_r;
    done_n = done_r;
    step_n = 1'b0;
    if (load_s) begin
      done_n = 1'b0;
      if (bus.mode == MODE_DOWN) begin
        pos_n = POS_LAST;
        dir_n = 1'b1;
      end else begin
        pos_n = '0;
        dir_n = 1'b0;
      end
    end else if (adv_s) begin
      step_n = 1'b1;
      case (mode_e'(mode_q_r))
        MODE_UP: begin
          dir_n = 1'b0;
          if (pos_r >= POS_LAST) pos_n = '0;
          else                   pos_n = pos_inc_s;
        end
        MODE_DOWN: begin
          dir_n = 1'b1;
          if (pos_r == '0) pos_n = POS_LAST;
          else             pos_n = pos_dec_s;
        end
        MODE_PING: begin
          if (!dir_r) begin
            // Upward leg; turning around on the step that reaches the top.
            if (pos_r >= POS_LAST) begin
              pos_n = POS_LAST;
              dir_n = 1'b1;
            end else begin
              pos_n = pos_inc_s;
              dir_n = (pos_inc_s == POS_LAST);
            end
          end else begin
            // Downward leg; turning around on the step that reaches zero.
            if (pos_r == '0) begin
              pos_n = '0;
              dir_n = 1'b0;
            end else begin
              pos_n = pos_dec_s;
              dir_n = (pos_dec_s != '0);
            end
          end
        end
        MODE_ONCE: begin
          dir_n = 1'b0;
          if ((pos_r >= POS_LAST) || (pos_inc_s >= POS_LAST)) begin
            pos_n  = POS_LAST;
            done_n = 1'b1;
          end else begin
            pos_n  = pos_inc_s;
          end
        end
        default: begin
          pos_n = '0;
          dir_n = 1'b0;
        end
      endcase
    end else begin
      step_n = 1'b0;
    end
  end

  // State registers; every output is taken directly from one of these.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_r    <= '0;
      pos_r    <= '0;
      step_r   <= 1'b0;
      dir_r    <= 1'b0;
      done_r   <= 1'b0;
      mode_q_r <= 2'b00;
    end else begin
      cnt_r    <= cnt_n;
      pos_r    <= pos_n;
      step_r   <= step_n;
      dir_r    <= dir_n;
      done_r   <= done_n;
      mode_q_r <= bus.mode;
    end
  end

  assign bus.pos  = pos_r;
  assign bus.step = step_r;
  assign bus.dir  = dir_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_scroll_step_gen.sv
// tb_scroll_step_gen: directed scenarios plus a randomized phase, all checked
// cycle by cycle against a step-count based reference model.
// Parameters: CLK_HZ=100, STEP_HZ=10 (10 clocks per step), POS_MAX=5.
module tb_scroll_step_gen;
  localparam int DIV = 10;
  localparam int PM  = 5;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  scroll_step_gen_if #(.POS_W(3)) bus ();

  scroll_step_gen #(.CLK_HZ(100), .STEP_HZ(10), .POS_MAX(PM)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus values
  logic       d_en, d_restart;
  logic [1:0] d_mode;
  logic [1:0] d_rate;

  // reference model state: steps since start, clocks since tick
  int m_k, m_ph, m_post, m_run, m_mode_q, m_rate_q;
  bit m_step;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_pos(input int md, input int k);
    int p;
    case (md)
      0: return k % (PM + 1);
      1: return PM - (k % (PM + 1));
      2: begin
        p = k % (2 * PM);
        return (p <= PM) ? p : 2 * PM - p;
      end
      default: return (k >= PM) ? PM : k;
    endcase
  endfunction

  function automatic int exp_dir(input int md, input int k);
    if (md == 1) return 1;
    if (md == 2) return ((k % (2 * PM)) >= PM) ? 1 : 0;
    return 0;
  endfunction

  function automatic int exp_done(input int md, input int k);
    return (md == 3 && k >= PM) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_k = 0; m_ph = 0; m_post = 0; m_run = 0;
    m_mode_q = 0; m_rate_q = 0; m_step = 0;
  endtask

  task automatic model_step();
    bit tick;
    tick   = 0;
    m_step = 0;
    if (d_restart || int'(d_mode) != m_mode_q) begin
      m_k = 0; m_ph = 0; m_post = 0; m_run = int'(d_mode);
    end else begin
      if (d_en && exp_done(m_run, m_k) == 0) begin
        m_ph++;
        if (m_ph == DIV) begin
          m_ph = 0;
          tick = 1;
        end
      end
`ifdef RATE_SEL_EN
      if (int'(d_rate) != m_rate_q) m_post = 0;
      else if (tick) begin
        m_post++;
        if (m_post == (1 << d_rate)) begin
          m_post = 0; m_k++; m_step = 1;
        end
      end
`else
      if (tick) begin
        m_k++; m_step = 1;
      end
`endif
    end
    m_mode_q = int'(d_mode);
    m_rate_q = int'(d_rate);
  endtask

  task automatic drive();
    bus.en      = d_en;
    bus.mode    = d_mode;
    bus.restart = d_restart;
`ifdef RATE_SEL_EN
    bus.rate_sel = d_rate;
`endif
  endtask

  task automatic compare_all();
    check_val("pos",  int'(bus.pos),  exp_pos(m_run, m_k));
    check_val("step", int'(bus.step), int'(m_step));
    check_val("dir",  int'(bus.dir),  exp_dir(m_run, m_k));
    check_val("done", int'(bus.done), exp_done(m_run, m_k));
  endtask

  task automatic run_cycle();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // cycles until the next step pulse, -1 on timeout
  task automatic wait_step(input int max, output int n);
    bit seen;
    seen = 0;
    n = -1;
    for (int i = 1; i <= max; i++) begin
      if (!seen) begin
        run_cycle();
        if (bus.step) begin
          n = i;
          seen = 1;
        end
      end
    end
  endtask

  int n, cnt_steps, guard;
  int pp_pos [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int pp_dir [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    d_en = 1'b1; d_mode = 2'b00; d_restart = 1'b0; d_rate = 2'd0;
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_pos",  int'(bus.pos),  0);
    check_val("rst_step", int'(bus.step), 0);
    check_val("rst_dir",  int'(bus.dir),  0);
    check_val("rst_done", int'(bus.done), 0);
    nrst = 1'b1;

    // wrap-up: first step after DIV clocks, then steady period
    wait_step(30, n);
    check_val("first_step", n, 10);
    check_val("first_pos", int'(bus.pos), 1);
    wait_step(30, n);
    check_val("period", n, 10);

    // wrap-up -> wrap-down switch at pos 4
    guard = 0;
    while (exp_pos(m_run, m_k) != 4 && guard < 100) begin
      run_cycle();
      guard++;
    end
    check_val("reach_pos4", int'(bus.pos), 4);
    d_mode = 2'b01;
    run_cycle();
    check_val("sw_pos",  int'(bus.pos),  PM);
    check_val("sw_dir",  int'(bus.dir),  1);
    check_val("sw_step", int'(bus.step), 0);
    wait_step(30, n);
    check_val("sw_lat", n, 10);
    check_val("sw_next", int'(bus.pos), PM - 1);

    // ping-pong sweep
    d_mode = 2'b10;
    run_cycle();
    for (int i = 0; i < 11; i++) begin
      wait_step(30, n);
      check_val("pp_pos", int'(bus.pos), pp_pos[i]);
      check_val("pp_dir", int'(bus.dir), pp_dir[i]);
    end

    // one-shot
    d_mode = 2'b11;
    run_cycle();
    for (int i = 1; i <= PM; i++) begin
      wait_step(30, n);
      check_val("os_pos", int'(bus.pos), i);
      check_val("os_done", int'(bus.done), (i == PM) ? 1 : 0);
    end
    cnt_steps = 0;
    for (int i = 0; i < 100; i++) begin
      run_cycle();
      if (bus.step) cnt_steps++;
    end
    check_val("os_quiet", cnt_steps, 0);
    d_restart = 1'b1;
    run_cycle();
    d_restart = 1'b0;
    check_val("os_rs_pos",  int'(bus.pos),  0);
    check_val("os_rs_done", int'(bus.done), 0);
    wait_step(30, n);
    check_val("os_rs_lat", n, 10);

    // enable freeze at cnt=6
    d_mode = 2'b00;
    run_cycle();
    repeat (6) run_cycle();
    d_en = 1'b0;
    cnt_steps = 0;
    for (int i = 0; i < 37; i++) begin
      run_cycle();
      if (bus.step) cnt_steps++;
    end
    check_val("en_quiet", cnt_steps, 0);
    check_val("en_hold_pos", int'(bus.pos), 0);
    d_en = 1'b1;
    wait_step(30, n);
    check_val("en_resume", n, 4);
    check_val("en_pos", int'(bus.pos), 1);

    // asynchronous reset mid-count with nonzero outputs
    d_mode = 2'b01;
    repeat (15) run_cycle();
    #2 nrst = 1'b0;
    #1;
    check_val("arst_pos",  int'(bus.pos),  0);
    check_val("arst_step", int'(bus.step), 0);
    check_val("arst_dir",  int'(bus.dir),  0);
    check_val("arst_done", int'(bus.done), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    repeat (25) run_cycle();

`ifdef RATE_SEL_EN
    d_mode = 2'b00;
    d_rate = 2'd2;
    d_restart = 1'b1;
    run_cycle();
    d_restart = 1'b0;
    wait_step(100, n);
    check_val("rate_first", n, 40);
    wait_step(100, n);
    check_val("rate_period", n, 40);
    repeat (15) run_cycle();
    d_rate = 2'd0;
    wait_step(30, n);
    check_val("rate_fast", (n >= 1 && n <= 10) ? 1 : 0, 1);
`endif

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      d_restart = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 99) < 2) d_mode = 2'($urandom_range(0, 3));
      d_en = ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0;
`ifdef RATE_SEL_EN
      if ($urandom_range(0, 99) < 1) d_rate = 2'($urandom_range(0, 3));
`endif
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scroll_step_gen.md
Name: scroll_step_gen

Overview:
Parametrised position sequencer for seven-segment/LCD scrolling and barrel-shift displays. Divides the system clock down to a step rate and advances a position index 0..POS_MAX. Four run modes are supported: wrap-up, wrap-down, ping-pong and one-shot. Its `pos` output drives the display mux/shifter, and its `step` pulse can trigger downstream refreshes.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
STEP_HZ, 2, position update rate in Hz; DIV = CLK_HZ/STEP_HZ (integer division), elaboration error if DIV < 2
POS_MAX, 7, last position index; elaboration error if POS_MAX < 1
POS_W, $clog2(POS_MAX+1), position width (derived localparam)
CNT_W, $clog2(DIV), prescaler width (derived localparam)

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes prescaler and position
mode  in  2  00 wrap-up, 01 wrap-down, 10 ping-pong, 11 one-shot
restart  in  1  synchronous single-cycle restart request
pos  out  POS_W  current position index
step  out  1  one-cycle pulse in the cycle `pos` takes a new value
dir  out  1  current direction, 0 = up, 1 = down
done  out  1  one-shot finished flag (sticky)

Behaviour:
- Reset (nrst low, asynchronous): prescaler=0, pos=0, step=0, dir=0, done=0, mode_q=00.
- Prescaler: counts 0..DIV-1 while en=1 and not done; tick is internal, asserted when cnt==DIV-1, then cnt returns to 0.
  - Exactly DIV clocks per step; this is deliberately not DIV+1.
- Start position: the start value is loaded on a restart or on a change of `mode`.
  - Start position is pos=POS_MAX, dir=1 for mode 01; pos=0, dir=0 for all others.
  - A restart also clears the prescaler and `done`.
- Mode change: mode is registered into mode_q every cycle. mode != mode_q acts as an implicit restart in the following cycle, with the new mode.
- restart has priority over tick in the same cycle. No step pulse is generated for a restart load.
- On tick, pos is updated and step=1 for exactly that cycle:
  - 00: pos+1, POS_MAX wraps to 0. dir=0.
  - 01: pos-1, 0 wraps to POS_MAX. dir=1.
  - 10: dir=0: pos+1; on reaching POS_MAX, dir becomes 1 in the same cycle. dir=1: pos-1; on reaching 0, dir becomes 0. Each endpoint appears once per sweep; sequence for POS_MAX=3 is 0,1,2,3,2,1,0,1...
  - 11: pos+1 until POS_MAX. The tick that loads POS_MAX also sets done=1. Afterwards the prescaler is stopped, there are no further ticks or steps, and pos holds POS_MAX until restart or mode change.
- Non-power-of-two POS_MAX: pos never exceeds POS_MAX. Wrap is by compare, not by natural overflow.
- en low: all state held; restart and mode change are still honoured. en high resumes counting from the held cnt.
- Latency: step and new pos are registered and visible together in the cycle after the tick condition. All outputs come straight from flops.

Optional Feature:
Macro RATE_SEL_EN.
- Defined: adds input port `rate_sel` (2 bits).
  - Effective divide becomes DIV << rate_sel, i.e. 1x, 2x, 4x or 8x slower.
  - Implemented with a 3-bit post-counter counting ticks; `step` fires when the post-counter reaches (1<<rate_sel)-1.
  - A change in rate_sel clears the post-counter.
- Undefined: no port and no post-counter; behaviour is exactly as above.

Test Plan:
- CLK_HZ=100, STEP_HZ=10, POS_MAX=7, mode=00, en=1 after reset -> first step 10 clocks after reset release; pos 0..7,0; step width 1 cycle; period exactly 10 clocks.
- mode=10, POS_MAX=3 -> pos sequence 0,1,2,3,2,1,0,1; dir goes high on the step that loads 3 and low on the step that loads 0.
- mode=11, POS_MAX=5 -> done=1 on the step that loads 5; no further steps for 100 clocks; pulse restart -> pos=0, done=0, next step after 10 clocks.
- Switch mode 00->01 while pos=4 -> next cycle pos=7, dir=1, no step pulse; next step gives pos=6.
- Hold en=0 for 37 clocks mid-count at cnt=6 -> pos and cnt frozen; step appears 4 clocks after en returns; nrst asserted mid-count -> all outputs 0 immediately (asynchronous).
- RATE_SEL_EN defined, rate_sel=2 -> step period 40 clocks; change rate_sel to 0 mid-period -> the next step follows within 10 clocks.
